// File: rtl/mem_unit_ws.sv
// mem_unit_ws: EDiC memory unit with wait states.
// It holds the PC, the SP, the MAR and the instruction latch.
// It decodes the RAM, stack and I/O pages and stalls the control unit
// while a slow RAM or I/O access is in progress.
// Optional feature: define MEM_BREAKPOINT_EN to add a registered PC
// breakpoint comparator and its ports.
module mem_unit_ws #(
  parameter int         PC_WIDTH   = 16,
  parameter int         SP_WIDTH   = 8,
  parameter int         RAM_WAIT   = 2,
  parameter int         IO_WAIT    = 4,
  parameter logic [7:0] STACK_PAGE = 8'hFF,
  parameter logic [7:0] IO_PAGE    = 8'hFE
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [7:0]          i_bus,
  output logic [7:0]          o_bus,
  output logic                o_busNOE,
  output logic [7:0]          o_instrCode,
  input  logic                i_ctrlPCLoadN,
  input  logic                i_ctrlPCNEn,
  input  logic                i_ctrlPCFromImm,
  input  logic                i_ctrlMemPCToRamN,
  input  logic                i_ctrlSpUp,
  input  logic                i_ctrlSpNEn,
  input  logic                i_ctrlInstrNWE,
  input  logic                i_ctrlInstrNOE,
  input  logic                i_ctrlRamNOE,
  input  logic                i_ctrlRamNWE,
  input  logic                i_ctrlMemMar0NWE,
  input  logic                i_ctrlMemMar1NWE,
  input  logic                i_ctrlMemInstrImmToRamAddr,
  input  logic                i_spFaultClr,
  output logic [PC_WIDTH-2:0] o_romAddress,
  input  logic [23:0]         i_romData,
  output logic [16:0]         o_ramAddress,
  input  logic [7:0]          i_ramData,
  output logic [7:0]          o_ramData,
  input  logic [7:0]          i_ram2Data,
  output logic [7:0]          o_ram2Data,
  output logic                o_ramWE,
  output logic                o_ramCE,
  output logic                o_ioSelect,
  output logic                o_ioNOE,
  output logic                o_ioNWE,
  output logic [7:0]          o_ioAddress,
  output logic                o_stall,
  output logic [1:0]          o_spFault
`ifdef MEM_BREAKPOINT_EN
  ,
  input  logic [15:0]         i_breakpointAddress,
  input  logic                i_breakpointEnableN,
  output logic                o_breakpointHitN
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // Counter preloads. The preload is unused when the matching wait count is zero.
  localparam logic [7:0] RAM_WAIT_M1 = 8'(RAM_WAIT - 1);
  localparam logic [7:0] IO_WAIT_M1  = 8'(IO_WAIT - 1);
  localparam bit         RAM_ZERO    = (RAM_WAIT == 0);
  localparam bit         IO_ZERO     = (IO_WAIT == 0);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic [15:0]         mar_q, mar_d;
  logic [15:0]         imm_q, imm_d;
  logic [7:0]          code_q, code_d;
  logic [1:0]          fault_q, fault_d;
  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                blocked_q, blocked_d;  // must see strobes high before the next access
  logic                rd_q, rd_d;            // the access in flight is a RAM read

  logic [15:0] sel_addr;
  logic [7:0]  page;
  logic        stack_sel, io_sel, access, wait_zero, upd_en, ram_rd_now;
  logic [15:0] pc16;

  // Address select: the immediate or the MAR supplies the page and the low byte.
  assign sel_addr  = i_ctrlMemInstrImmToRamAddr ? imm_q : mar_q;
  assign page      = sel_addr[15:8];
  assign stack_sel = (page == STACK_PAGE);
  assign io_sel    = (page == IO_PAGE);
  assign access    = ~i_ctrlRamNOE | ~i_ctrlRamNWE;
  assign wait_zero = io_sel ? IO_ZERO : RAM_ZERO;
  assign pc16      = 16'(pc_q);

  assign o_ramAddress = stack_sel ? {1'b1, 8'(sp_q), sel_addr[7:0]}
                                  : {1'b0, sel_addr};
  assign o_ioSelect   = io_sel;
  assign o_ioAddress  = sel_addr[7:0];
  assign o_ramCE      = access & ~io_sel;
  assign o_ramWE      = ~i_ctrlRamNWE & ~io_sel;
  assign o_ioNOE      = i_ctrlRamNOE | ~io_sel;
  assign o_ioNWE      = i_ctrlRamNWE | ~io_sel;
  assign o_ramData    = i_ctrlMemPCToRamN ? i_bus : pc16[7:0];
  assign o_ram2Data   = i_ctrlMemPCToRamN ? 8'h00 : pc16[15:8];
  assign o_romAddress = pc_q[PC_WIDTH-2:0];
  assign o_instrCode  = code_q;
  assign o_spFault    = fault_q;

  // A stall is the WAIT state only, so o_stall drops as soon as reset forces IDLE.
  assign o_stall = (state_q == S_WAIT);
  assign upd_en  = ~o_stall;

  // RAM read data is presented in DONE, or in the IDLE cycle of a zero-wait read.
  assign ram_rd_now = ((state_q == S_DONE) && rd_q) ||
                      ((state_q == S_IDLE) && !blocked_q && wait_zero &&
                       !i_ctrlRamNOE && !io_sel);
  assign o_bus    = ram_rd_now ? i_ramData : imm_q[7:0];
  assign o_busNOE = ~(ram_rd_now | ~i_ctrlInstrNOE);

  // Wait-state FSM next state: IDLE -> WAIT (N cycles) -> DONE -> IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blocked_d = blocked_q;
    rd_d      = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (!access) begin
          blocked_d = 1'b0;
        end else if (!blocked_q && !wait_zero) begin
          state_d = S_WAIT;
          cnt_d   = io_sel ? IO_WAIT_M1 : RAM_WAIT_M1;
          rd_d    = ~i_ctrlRamNOE & ~io_sel;
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        blocked_d = 1'b1;
        rd_d      = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      blocked_q <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      blocked_q <= blocked_d;
      rd_q      <= rd_d;
    end
  end

  // Datapath next state. Everything except the fault clear freezes while stalled.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    mar_d   = mar_q;
    imm_d   = imm_q;
    code_d  = code_q;
    fault_d = fault_q;
    if (i_spFaultClr) fault_d = 2'b00;
    if (upd_en) begin
      if (!i_ctrlPCNEn) begin
        if (i_ctrlPCLoadN)        pc_d = pc_q + PC_WIDTH'(1);
        else if (i_ctrlPCFromImm) pc_d = PC_WIDTH'(imm_q);
        else                      pc_d = PC_WIDTH'({i_ram2Data, i_bus});
      end
      if (!i_ctrlSpNEn) begin
        if (i_ctrlSpUp) begin
          sp_d = sp_q + SP_WIDTH'(1);
          if (&sp_q) fault_d[0] = 1'b1;   // underflow: pop past the stack top
        end else begin
          sp_d = sp_q - SP_WIDTH'(1);
          if (sp_q == '0) fault_d[1] = 1'b1;  // overflow: push past the bottom
        end
      end
      if (!i_ctrlMemMar0NWE) mar_d[7:0]  = i_bus;
      if (!i_ctrlMemMar1NWE) mar_d[15:8] = i_bus;
      if (!i_ctrlInstrNWE) begin
        code_d = i_romData[23:16];
        imm_d  = i_romData[15:0];
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_q    <= '0;
      sp_q    <= '0;
      mar_q   <= 16'h0000;
      imm_q   <= 16'h0000;
      code_q  <= 8'h00;
      fault_q <= 2'b00;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      mar_q   <= mar_d;
      imm_q   <= imm_d;
      code_q  <= code_d;
      fault_q <= fault_d;
    end
  end

`ifdef MEM_BREAKPOINT_EN
  logic bp_hit_n_q;

  // Breakpoint latch: it falls the cycle after a PC match and holds until disabled.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                             bp_hit_n_q <= 1'b1;
    else if (i_breakpointEnableN)            bp_hit_n_q <= 1'b1;
    else if (pc16 == i_breakpointAddress)    bp_hit_n_q <= 1'b0;
  end

  assign o_breakpointHitN = bp_hit_n_q;
`endif

endmodule

// File: tb/tb_mem_unit_ws.sv
// Bench for mem_unit_ws: directed stimulus pushes cycle-stamped expectations;
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_unit_ws;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  dut_bus, bus_net, tb_drv, ram_data, ram2_data, o_ram_data, o_ram2_data;
  logic        tb_drv_en, bus_noe;
  logic [7:0]  instr_code, io_addr;
  logic        pc_load_n, pc_n_en, pc_from_imm, pc_to_ram_n, sp_up, sp_n_en;
  logic        instr_nwe, instr_noe, ram_noe, ram_nwe, mar0_nwe, mar1_nwe, imm_to_addr, flt_clr;
  logic [14:0] rom_addr;
  logic [23:0] rom_data;
  logic [16:0] ram_addr;
  logic        ram_we, ram_ce, io_sel, io_noe, io_nwe, stall;
  logic [1:0]  fault;
`ifdef MEM_BREAKPOINT_EN
  logic [15:0] bp_addr;
  logic        bp_en_n, bp_hit_n;
`endif

  // Shared bus with pull-up: the DUT, the bench, or 8'hFF when nobody drives it.
  assign bus_net = !bus_noe ? dut_bus : (tb_drv_en ? tb_drv : 8'hFF);

  mem_unit_ws dut (
    .i_clk(clk), .i_reset(rst), .i_bus(bus_net), .o_bus(dut_bus), .o_busNOE(bus_noe),
    .o_instrCode(instr_code), .i_ctrlPCLoadN(pc_load_n), .i_ctrlPCNEn(pc_n_en),
    .i_ctrlPCFromImm(pc_from_imm), .i_ctrlMemPCToRamN(pc_to_ram_n), .i_ctrlSpUp(sp_up),
    .i_ctrlSpNEn(sp_n_en), .i_ctrlInstrNWE(instr_nwe), .i_ctrlInstrNOE(instr_noe),
    .i_ctrlRamNOE(ram_noe), .i_ctrlRamNWE(ram_nwe), .i_ctrlMemMar0NWE(mar0_nwe),
    .i_ctrlMemMar1NWE(mar1_nwe), .i_ctrlMemInstrImmToRamAddr(imm_to_addr),
    .i_spFaultClr(flt_clr), .o_romAddress(rom_addr), .i_romData(rom_data),
    .o_ramAddress(ram_addr), .i_ramData(ram_data), .o_ramData(o_ram_data),
    .i_ram2Data(ram2_data), .o_ram2Data(o_ram2_data), .o_ramWE(ram_we), .o_ramCE(ram_ce),
    .o_ioSelect(io_sel), .o_ioNOE(io_noe), .o_ioNWE(io_nwe), .o_ioAddress(io_addr),
    .o_stall(stall), .o_spFault(fault)
`ifdef MEM_BREAKPOINT_EN
    , .i_breakpointAddress(bp_addr), .i_breakpointEnableN(bp_en_n), .o_breakpointHitN(bp_hit_n)
`endif
  );

  localparam int S_ROM = 0, S_STALL = 1, S_BUSNOE = 2, S_BUS = 3, S_FAULT = 4, S_RAMADDR = 5;
  localparam int S_IOSEL = 6, S_RAMCE = 7, S_IONWE = 8, S_INSTR = 9, S_RAMWE = 10;
  localparam int S_BPHIT = 11, S_IOADDR = 12;

  typedef struct { int cyc; int sig; logic [31:0] val; } exp_t;
  exp_t sbq[$];
  int n_checks = 0, n_fail = 0;

  function automatic string sname(int s);
    case (s)
      S_ROM: return "romAddress";   S_STALL: return "stall";   S_BUSNOE: return "busNOE";
      S_BUS: return "bus";          S_FAULT: return "spFault"; S_RAMADDR: return "ramAddress";
      S_IOSEL: return "ioSelect";   S_RAMCE: return "ramCE";   S_IONWE: return "ioNWE";
      S_INSTR: return "instrCode";  S_RAMWE: return "ramWE";   S_BPHIT: return "breakpointHitN";
      default: return "ioAddress";
    endcase
  endfunction

  function automatic logic [31:0] sample(int s);
    case (s)
      S_ROM: return 32'(rom_addr);      S_STALL: return 32'(stall);
      S_BUSNOE: return 32'(bus_noe);    S_BUS: return 32'(dut_bus);
      S_FAULT: return 32'(fault);       S_RAMADDR: return 32'(ram_addr);
      S_IOSEL: return 32'(io_sel);      S_RAMCE: return 32'(ram_ce);
      S_IONWE: return 32'(io_nwe);      S_INSTR: return 32'(instr_code);
      S_RAMWE: return 32'(ram_we);
`ifdef MEM_BREAKPOINT_EN
      S_BPHIT: return 32'(bp_hit_n);
`endif
      default: return 32'(io_addr);
    endcase
  endfunction

  task automatic chk(int s, logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.val = v;
    sbq.push_back(e);
  endtask

  // Monitor: compare every expectation due in this cycle, away from the clock edge.
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e = sbq.pop_front();
      got = sample(e.sig);
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d", sname(e.sig), e.cyc, cyc);
      end else if (got !== e.val) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %0h, expected %0h", sname(e.sig), cyc, got, e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    pc_load_n = 1; pc_n_en = 1; pc_from_imm = 0; pc_to_ram_n = 1; sp_up = 0; sp_n_en = 1;
    instr_nwe = 1; instr_noe = 1; ram_noe = 1; ram_nwe = 1; mar0_nwe = 1; mar1_nwe = 1;
    imm_to_addr = 0; flt_clr = 0; tb_drv_en = 0; tb_drv = 8'h00;
  endtask

  initial begin
    defaults();
    rom_data = 24'h0; ram_data = 8'h00; ram2_data = 8'h00;
`ifdef MEM_BREAKPOINT_EN
    bp_addr = 16'h0005; bp_en_n = 1'b1;
`endif
    rst = 1'b1;
    step();
    // Reset state
    chk(S_ROM, 0); chk(S_STALL, 0); chk(S_BUSNOE, 1); chk(S_FAULT, 0);
    chk(S_RAMADDR, 0); chk(S_INSTR, 0);
`ifdef MEM_BREAKPOINT_EN
    chk(S_BPHIT, 1);
`endif
    rst = 1'b0;

    // PC increments three times.
    pc_n_en = 0;
    step(); chk(S_ROM, 1);
    step(); step(); pc_n_en = 1; chk(S_ROM, 3);

    // Instruction latch, then a PC load from the immediate.
    rom_data = 24'hAB1234; instr_nwe = 0;
    step(); instr_nwe = 1; pc_n_en = 0; pc_load_n = 0; pc_from_imm = 1; instr_noe = 0;
    chk(S_INSTR, 8'hAB); chk(S_BUSNOE, 0); chk(S_BUS, 8'h34);
    step(); defaults(); chk(S_ROM, 15'h1234);

    // PC load from {ram2, bus}, then wrap-around from all-ones.
    ram2_data = 8'h56; tb_drv_en = 1; tb_drv = 8'h78; pc_n_en = 0; pc_load_n = 0;
    step(); chk(S_ROM, 15'h5678);
    ram2_data = 8'hFF; tb_drv_en = 0;
    step(); pc_load_n = 1; chk(S_ROM, 15'h7FFF);
    step(); defaults(); chk(S_ROM, 0);

    // MAR = 16'h0010, then a RAM read with 2 wait states.
    tb_drv_en = 1; tb_drv = 8'h10; mar0_nwe = 0;
    step(); mar0_nwe = 1; tb_drv = 8'h00; mar1_nwe = 0;
    step(); defaults(); chk(S_RAMADDR, 17'h00010);
    ram_data = 8'hC3; ram_noe = 0;
    chk(S_STALL, 0); chk(S_RAMCE, 1); chk(S_BUSNOE, 1);
    step(); pc_n_en = 0; chk(S_STALL, 1); chk(S_ROM, 0);
    step(); chk(S_STALL, 1); chk(S_ROM, 0);
    step(); ram_noe = 1; pc_n_en = 1;
    chk(S_STALL, 0); chk(S_BUSNOE, 0); chk(S_BUS, 8'hC3); chk(S_ROM, 0);
    step(); chk(S_STALL, 0); chk(S_BUSNOE, 1); chk(S_ROM, 0);

    // I/O write at 16'hFE05 with 4 wait states.
    tb_drv_en = 1; tb_drv = 8'hFE; mar1_nwe = 0;
    step(); mar1_nwe = 1; tb_drv = 8'h05; mar0_nwe = 0;
    step(); defaults(); ram_nwe = 0;
    chk(S_IOSEL, 1); chk(S_RAMCE, 0); chk(S_RAMWE, 0); chk(S_IONWE, 0);
    chk(S_STALL, 0); chk(S_IOADDR, 8'h05);
    for (int i = 0; i < 4; i++) begin
      step(); chk(S_STALL, 1); chk(S_IONWE, 0);
    end
    step(); ram_nwe = 1; chk(S_STALL, 0); chk(S_IONWE, 1);
    step(); chk(S_STALL, 0);

    // Stack page: MAR high byte from an undriven bus gives 8'hFF.
    mar1_nwe = 0;
    step(); defaults(); chk(S_RAMADDR, 17'h10005);
    sp_n_en = 0; sp_up = 0;
    step(); defaults(); chk(S_RAMADDR, 17'h1FF05); chk(S_FAULT, 2'b10);
    flt_clr = 1;
    step(); defaults(); chk(S_FAULT, 2'b00); chk(S_RAMADDR, 17'h1FF05);
    sp_n_en = 0; sp_up = 1;
    step(); defaults(); chk(S_FAULT, 2'b01); chk(S_RAMADDR, 17'h10005);
    sp_n_en = 0; sp_up = 0; flt_clr = 1;   // a raise beats a clear in the same cycle
    step(); defaults(); chk(S_FAULT, 2'b10); chk(S_RAMADDR, 17'h1FF05);

    // Reset asserted in WAIT.
    tb_drv_en = 1; tb_drv = 8'h00; mar1_nwe = 0;
    step(); defaults(); ram_noe = 0;
    step(); chk(S_STALL, 1);
    step(); rst = 1'b1; ram_noe = 1;
    chk(S_STALL, 0); chk(S_RAMADDR, 0); chk(S_FAULT, 0);
    step(); rst = 1'b0; chk(S_STALL, 0);
    mar0_nwe = 0;
    step(); defaults(); chk(S_RAMADDR, 17'h000FF);

`ifdef MEM_BREAKPOINT_EN
    // Breakpoint at 16'h0005 while the PC counts up.
    bp_en_n = 1'b0; pc_n_en = 0;
    for (int k = 1; k <= 8; k++) begin
      step(); chk(S_ROM, k); chk(S_BPHIT, (k >= 6) ? 0 : 1);
    end
    bp_en_n = 1'b1; pc_n_en = 1;
    step(); chk(S_BPHIT, 1);
`endif

    step(); step();
    if (sbq.size() > 0) begin
      n_fail += sbq.size();
      $display("FAIL scoreboard: %0d expectations never compared", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_unit_ws.md
# mem_unit_ws

Parametrised second-generation memory unit for the EDiC datapath. Holds the program counter, stack pointer, memory address register (MAR) and instruction latch, and decodes RAM, stack and I/O pages. Adds behaviour the first-generation unit lacked:
- configurable widths and page codes;
- a wait-state state machine that stalls the control unit for slow RAM and I/O;
- a sticky stack-fault flag.

## Interface
Parameters:
- PC_WIDTH, 16: program counter width; ROM address is PC[PC_WIDTH-2:0]
- SP_WIDTH, 8: stack pointer width; must be ≤ 8
- RAM_WAIT, 2: extra cycles per RAM/stack access (0 = single-cycle)
- IO_WAIT, 4: extra cycles per I/O access
- STACK_PAGE, 8'hFF: high-byte code selecting stack memory
- IO_PAGE, 8'hFE: high-byte code selecting I/O

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_bus  in  8  data bus input; high-Z reads as 8'hFF (pull-up)
- o_bus / o_busNOE  out  8/1  tristate-net bus drive and its active-low enable
- o_instrCode  out  8  latched opcode
- i_ctrlPCLoadN, i_ctrlPCNEn, i_ctrlPCFromImm, i_ctrlMemPCToRamN, i_ctrlSpUp, i_ctrlSpNEn, i_ctrlInstrNWE, i_ctrlInstrNOE, i_ctrlRamNOE, i_ctrlRamNWE, i_ctrlMemMar0NWE, i_ctrlMemMar1NWE, i_ctrlMemInstrImmToRamAddr  in  1 each  control word; same meanings as gen 1
- i_spFaultClr  in  1  clears o_spFault
- o_romAddress / i_romData  out/in  PC_WIDTH-1 / 24  instruction ROM address and data
- o_ramAddress  out  17  bit 16 = stack select
- i_ramData / o_ramData / i_ram2Data / o_ram2Data  in/out/in/out  8 each  RAM data ports
- o_ramWE, o_ramCE, o_ioSelect, o_ioNOE, o_ioNWE  out  1 each  RAM/I/O strobes
- o_ioAddress  out  8  I/O register address
- o_stall  out  1  high while a wait-state access is in progress
- o_spFault  out  2  sticky fault flags: [1] stack overflow, [0] stack underflow
- i_breakpointAddress, i_breakpointEnableN, o_breakpointHitN  in/in/out  16/1/1  present only with MEM_BREAKPOINT_EN

## Operation
- Address select:
  - the page byte is instrImm[15:8] when i_ctrlMemInstrImmToRamAddr=1, otherwise MAR[15:8];
  - stack page gives address {1, SP zero-extended, low byte};
  - I/O page asserts o_ioSelect and deasserts o_ramCE.
- PC:
  - PCNEn=0 with LoadN=1: PC+1, wraps modulo 2^PC_WIDTH;
  - PCNEn=0 with LoadN=0: load instrImm when PCFromImm=1, otherwise {i_ram2Data, i_bus}.
- SP:
  - SpNEn=0: SP±1 modulo 2^SP_WIDTH;
  - decrement from 0 sets o_spFault[1] (overflow);
  - increment from the all-ones value sets o_spFault[0] (underflow).
- Fault flags: sticky.
  - i_spFaultClr clears both flags.
  - A fault raised in the same cycle as a clear wins.
- MAR bytes load from i_bus; a high-Z bus loads 8'hFF.
- Instruction latch: InstrNWE=0 loads o_instrCode=i_romData[23:16] and instrImm=i_romData[15:0].
- Wait-state FSM, states IDLE → WAIT → DONE → IDLE:
  - An access is RamNOE=0 or RamNWE=0 (either strobe low).
  - From IDLE, an access with a nonzero wait count enters WAIT. The counter loads IO_WAIT-1 for the I/O page, otherwise RAM_WAIT-1.
  - WAIT decrements the counter; at 0 it moves to DONE.
  - DONE returns to IDLE next cycle, even if the strobe is still low. A new access needs one IDLE cycle with both strobes high.
  - With a zero wait count the access completes in the IDLE cycle; the FSM stays in IDLE.
- While o_stall=1, all PC/SP/MAR/instruction updates are suppressed. The control unit holds its control word during the stall.

## Timing
- Reset values (immediate, asynchronous):
  - PC, SP, MAR, instrImm, o_instrCode = 0;
  - FSM = IDLE; o_stall = 0; o_spFault = 0;
  - o_busNOE = 1 unless a bus source is enabled.
- o_stall is high in WAIT only. It rises in the cycle after the access strobe is first seen low (registered FSM).
- Access length:
  - an access of N wait states occupies N+1 cycles of strobe-low;
  - o_ramWE / o_ioNWE follow RamNWE for the whole access;
  - RAM read data goes on the bus during DONE, or during the single IDLE cycle when N=0.
- Reset asserted mid-access: FSM returns to IDLE at once, o_stall drops asynchronously, and no register update commits.
- Bus and addresses are combinational from the current registers and control; registers update on the edge.

## Configuration
- MEM_BREAKPOINT_EN defined:
  - the breakpoint ports exist;
  - o_breakpointHitN is registered and goes low the cycle after PC equals i_breakpointAddress while i_breakpointEnableN=0;
  - it then stays low until reset or i_breakpointEnableN=1.
- MEM_BREAKPOINT_EN undefined: the breakpoint ports and logic are absent.

## Test plan
- Reset, then PCNEn=0, LoadN=1 for 3 cycles → PC=3, o_romAddress=3; load with FromImm, instrImm=16'h1234 → PC=16'h1234.
- RAM_WAIT=2: RAM read at MAR=16'h0010 → o_stall high for exactly 2 cycles, i_ramData on bus in DONE; PC increment commanded during the stall → PC unchanged.
- IO_WAIT=4: MAR high byte 8'hFE, RamNWE=0 → o_ioSelect=1, o_ramCE=0, stall 4 cycles, o_ioNWE low for 5 cycles.
- SP=0, SpNEn=0, SpUp=0 → SP=8'hFF, o_spFault=2'b10; i_spFaultClr → 2'b00; SP=8'hFF, SpUp=1 → SP=0, o_spFault=2'b01.
- Assert i_reset during WAIT → o_stall=0 immediately, FSM in IDLE; MAR0 write from a high-Z bus after release → MAR[7:0]=8'hFF.
- MEM_BREAKPOINT_EN: breakpoint address 16'h0005, enable low, PC counts up → o_breakpointHitN falls the cycle after PC=5 and stays low.
